// File: rtl/alu_reservation_station.sv
// alu_reservation_station: holds ALU commands until their operands arrive on the CDB, then executes and broadcasts them
module alu_reservation_station #(
    parameter int SLOT_COUNT    = 2,
    parameter int DATA_WIDTH    = 4,
    parameter int CDB_TAG_WIDTH = 4,
    parameter int TAG_BASE      = 1,
    parameter int ALU_OP_WIDTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cdb_in_valid,
    input  logic [CDB_TAG_WIDTH-1:0] cdb_in_tag,
    input  logic [DATA_WIDTH-1:0]    cdb_in_data,
    input  logic                     alu_eu_command_update_en,
    input  logic [ALU_OP_WIDTH-1:0]  alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_eu_operand_a_data,
    input  logic                     alu_eu_operand_a_data_is_valid,
    input  logic [DATA_WIDTH-1:0]    alu_eu_operand_b_data,
    input  logic                     alu_eu_operand_b_data_is_valid,
    output logic                     alu_eu_command_update_accepted,
    output logic [CDB_TAG_WIDTH-1:0] alu_eu_command_result_cdb_tag,
    output logic                     cdb_out_valid,
    output logic [CDB_TAG_WIDTH-1:0] cdb_out_tag,
    output logic [DATA_WIDTH-1:0]    cdb_out_data,
    input  logic                     cdb_out_grant
);
    localparam int IW = SLOT_COUNT > 1 ? $clog2(SLOT_COUNT) : 1;

    typedef enum logic [1:0] {FREE, WAITING, READY, EXECUTING} slot_state_t;

    slot_state_t                 st     [SLOT_COUNT];
    slot_state_t                 st_n   [SLOT_COUNT];
    logic [ALU_OP_WIDTH-1:0]     op     [SLOT_COUNT];
    logic [ALU_OP_WIDTH-1:0]     op_n   [SLOT_COUNT];
    logic [DATA_WIDTH-1:0]       a      [SLOT_COUNT];
    logic [DATA_WIDTH-1:0]       a_n    [SLOT_COUNT];
    logic [DATA_WIDTH-1:0]       b      [SLOT_COUNT];
    logic [DATA_WIDTH-1:0]       b_n    [SLOT_COUNT];
    logic                        a_v    [SLOT_COUNT];
    logic                        a_v_n  [SLOT_COUNT];
    logic                        b_v    [SLOT_COUNT];
    logic                        b_v_n  [SLOT_COUNT];
    logic                        out_valid_n;
    logic [CDB_TAG_WIDTH-1:0]    out_tag_n;
    logic [DATA_WIDTH-1:0]       out_data_n;
    logic                        free_found, rdy_found, grant_fire, a_hit, b_hit;
    logic [IW-1:0]               free_idx, rdy_idx;

    function automatic logic [DATA_WIDTH-1:0] alu(input logic [ALU_OP_WIDTH-1:0] o,
                                                  input logic [DATA_WIDTH-1:0] x,
                                                  input logic [DATA_WIDTH-1:0] y);
        return o == ALU_OP_WIDTH'(0) ? x + y :
               o == ALU_OP_WIDTH'(1) ? x - y :
               o == ALU_OP_WIDTH'(2) ? x & y : x | y;
    endfunction

    // Lowest FREE slot for allocation and lowest READY slot for issue
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        rdy_found  = 1'b0;
        rdy_idx    = '0;
        for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
            if (st[i] == FREE) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
            if (st[i] == READY) begin
                rdy_found = 1'b1;
                rdy_idx   = IW'(i);
            end
        end
    end

    assign alu_eu_command_update_accepted = alu_eu_command_update_en && free_found;
    assign alu_eu_command_result_cdb_tag  = alu_eu_command_update_accepted ?
                                            CDB_TAG_WIDTH'(TAG_BASE) + CDB_TAG_WIDTH'(free_idx) : '0;
    assign grant_fire = cdb_out_valid && cdb_out_grant;
    assign a_hit = !alu_eu_operand_a_data_is_valid && cdb_in_valid &&
                   alu_eu_operand_a_data[CDB_TAG_WIDTH-1:0] == cdb_in_tag;
    assign b_hit = !alu_eu_operand_b_data_is_valid && cdb_in_valid &&
                   alu_eu_operand_b_data[CDB_TAG_WIDTH-1:0] == cdb_in_tag;

    // Next slot contents: CDB capture, release on grant, issue into the result register, allocation
    always_comb begin
        st_n        = st;
        op_n        = op;
        a_n         = a;
        b_n         = b;
        a_v_n       = a_v;
        b_v_n       = b_v;
        out_valid_n = cdb_out_valid && !cdb_out_grant;
        out_tag_n   = cdb_out_tag;
        out_data_n  = cdb_out_data;
        for (int i = 0; i < SLOT_COUNT; i++) begin
            if (st[i] == WAITING && cdb_in_valid) begin
                if (!a_v[i] && a[i][CDB_TAG_WIDTH-1:0] == cdb_in_tag) begin
                    a_n[i]   = cdb_in_data;
                    a_v_n[i] = 1'b1;
                end
                if (!b_v[i] && b[i][CDB_TAG_WIDTH-1:0] == cdb_in_tag) begin
                    b_n[i]   = cdb_in_data;
                    b_v_n[i] = 1'b1;
                end
            end
            if (st[i] == WAITING && a_v_n[i] && b_v_n[i])
                st_n[i] = READY;
            if (st[i] == EXECUTING && grant_fire)
                st_n[i] = FREE;
        end
        if (rdy_found && (!cdb_out_valid || cdb_out_grant)) begin
            st_n[rdy_idx] = EXECUTING;
            out_valid_n   = 1'b1;
            out_tag_n     = CDB_TAG_WIDTH'(TAG_BASE) + CDB_TAG_WIDTH'(rdy_idx);
            out_data_n    = alu(op[rdy_idx], a[rdy_idx], b[rdy_idx]);
        end
        if (alu_eu_command_update_accepted) begin
            op_n[free_idx]  = alu_op;
            a_n[free_idx]   = a_hit ? cdb_in_data : alu_eu_operand_a_data;
            b_n[free_idx]   = b_hit ? cdb_in_data : alu_eu_operand_b_data;
            a_v_n[free_idx] = alu_eu_operand_a_data_is_valid || a_hit;
            b_v_n[free_idx] = alu_eu_operand_b_data_is_valid || b_hit;
            st_n[free_idx]  = (alu_eu_operand_a_data_is_valid || a_hit) &&
                              (alu_eu_operand_b_data_is_valid || b_hit) ? READY : WAITING;
        end
    end

    // State register; reset drops every slot and any pending result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOT_COUNT; i++) begin
                st[i]  <= FREE;
                op[i]  <= '0;
                a[i]   <= '0;
                b[i]   <= '0;
                a_v[i] <= 1'b0;
                b_v[i] <= 1'b0;
            end
            cdb_out_valid <= 1'b0;
            cdb_out_tag   <= '0;
            cdb_out_data  <= '0;
        end else begin
            st            <= st_n;
            op            <= op_n;
            a             <= a_n;
            b             <= b_n;
            a_v           <= a_v_n;
            b_v           <= b_v_n;
            cdb_out_valid <= out_valid_n;
            cdb_out_tag   <= out_tag_n;
            cdb_out_data  <= out_data_n;
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// tb_alu_reservation_station: directed vector and sequence checks for the ALU reservation station
module tb_alu_reservation_station;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cdb_in_valid = 1'b0;
    logic [3:0] cdb_in_tag = '0;
    logic [3:0] cdb_in_data = '0;
    logic       update_en = 1'b0;
    logic [1:0] alu_op = '0;
    logic [3:0] a_data = '0;
    logic       a_valid = 1'b0;
    logic [3:0] b_data = '0;
    logic       b_valid = 1'b0;
    logic       accepted;
    logic [3:0] result_tag;
    logic       out_valid;
    logic [3:0] out_tag;
    logic [3:0] out_data;
    logic       grant = 1'b0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp;
    } vec_t;
    vec_t vecs[6];

    alu_reservation_station dut (
        .clk                            (clk),
        .rst                            (rst),
        .cdb_in_valid                   (cdb_in_valid),
        .cdb_in_tag                     (cdb_in_tag),
        .cdb_in_data                    (cdb_in_data),
        .alu_eu_command_update_en       (update_en),
        .alu_op                         (alu_op),
        .alu_eu_operand_a_data          (a_data),
        .alu_eu_operand_a_data_is_valid (a_valid),
        .alu_eu_operand_b_data          (b_data),
        .alu_eu_operand_b_data_is_valid (b_valid),
        .alu_eu_command_update_accepted (accepted),
        .alu_eu_command_result_cdb_tag  (result_tag),
        .cdb_out_valid                  (out_valid),
        .cdb_out_tag                    (out_tag),
        .cdb_out_data                   (out_data),
        .cdb_out_grant                  (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic cmd(input logic [1:0] op, input logic [3:0] a, input logic av,
                       input logic [3:0] b, input logic bv);
        update_en = 1'b1;
        alu_op    = op;
        a_data    = a;
        a_valid   = av;
        b_data    = b;
        b_valid   = bv;
    endtask

    task automatic chk_out(input string name, input int v, input int t, input int d);
        chk({name, "_valid"}, int'(out_valid), v);
        if (v != 0) begin
            chk({name, "_tag"}, int'(out_tag), t);
            chk({name, "_data"}, int'(out_data), d);
        end
    endtask

    initial begin
        vecs[0] = '{2'd0, 4'd3,  4'd4,  4'd7};
        vecs[1] = '{2'd1, 4'd2,  4'd5,  4'd13};
        vecs[2] = '{2'd0, 4'd9,  4'd9,  4'd2};
        vecs[3] = '{2'd2, 4'd12, 4'd10, 4'd8};
        vecs[4] = '{2'd3, 4'd5,  4'd10, 4'd15};
        vecs[5] = '{2'd1, 4'd7,  4'd3,  4'd4};

        step();
        #1;
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_tag", int'(out_tag), 0);
        chk("reset_data", int'(out_data), 0);
        rst = 1'b0;
        step();
        #1;
        chk("idle_accepted", int'(accepted), 0);
        chk("idle_tag", int'(result_tag), 0);

        // Each vector: accept in N, idle in N+1, result in N+2 granted, cleared in N+3
        for (int i = 0; i < 6; i++) begin
            step();
            cmd(vecs[i].op, vecs[i].a, 1'b1, vecs[i].b, 1'b1);
            #1;
            chk("vec_accepted", int'(accepted), 1);
            chk("vec_acc_tag", int'(result_tag), 1);
            step();
            update_en = 1'b0;
            #1;
            chk_out("vec_n1", 0, 0, 0);
            step();
            #1;
            chk_out("vec_n2", 1, 1, int'(vecs[i].exp));
            grant = 1'b1;
            step();
            grant = 1'b0;
            #1;
            chk_out("vec_n3", 0, 0, 0);
        end

        // Dependency on tag 5
        step();
        cmd(2'd0, 4'd5, 1'b0, 4'd1, 1'b1);
        #1;
        chk("dep_accepted", int'(accepted), 1);
        chk("dep_tag", int'(result_tag), 1);
        for (int i = 0; i < 4; i++) begin
            step();
            update_en = 1'b0;
            #1;
            chk_out("dep_wait", 0, 0, 0);
        end
        step();
        cdb_in_valid = 1'b1;
        cdb_in_tag   = 4'd5;
        cdb_in_data  = 4'd6;
        step();
        cdb_in_valid = 1'b0;
        #1;
        chk_out("dep_m1", 0, 0, 0);
        step();
        #1;
        chk_out("dep_m2", 1, 1, 7);
        grant = 1'b1;
        step();
        grant = 1'b0;
        #1;
        chk_out("dep_done", 0, 0, 0);

        // Same-cycle bypass of tag 7
        step();
        cmd(2'd0, 4'd7, 1'b0, 4'd3, 1'b1);
        cdb_in_valid = 1'b1;
        cdb_in_tag   = 4'd7;
        cdb_in_data  = 4'd2;
        #1;
        chk("byp_accepted", int'(accepted), 1);
        step();
        update_en    = 1'b0;
        cdb_in_valid = 1'b0;
        #1;
        chk_out("byp_n1", 0, 0, 0);
        step();
        #1;
        chk_out("byp_n2", 1, 1, 5);
        grant = 1'b1;
        step();
        grant = 1'b0;
        #1;
        chk_out("byp_done", 0, 0, 0);

        // Full station with backpressure
        step();
        cmd(2'd0, 4'd1, 1'b1, 4'd1, 1'b1);
        #1;
        chk("full_tag1", int'(result_tag), 1);
        step();
        cmd(2'd0, 4'd2, 1'b1, 4'd2, 1'b1);
        #1;
        chk("full_acc2", int'(accepted), 1);
        chk("full_tag2", int'(result_tag), 2);
        step();
        cmd(2'd3, 4'd1, 1'b1, 4'd2, 1'b1);
        #1;
        chk("full_rej", int'(accepted), 0);
        chk("full_rej_tag", int'(result_tag), 0);
        chk_out("full_hold0", 1, 1, 2);
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            chk("full_rej_hold", int'(accepted), 0);
            chk_out("full_hold", 1, 1, 2);
        end
        step();
        grant = 1'b1;
        #1;
        chk("full_rej_grant", int'(accepted), 0);
        step();
        grant = 1'b0;
        #1;
        chk_out("full_second", 1, 2, 4);
        chk("full_third_acc", int'(accepted), 1);
        chk("full_third_tag", int'(result_tag), 1);
        step();
        update_en = 1'b0;
        #1;
        chk_out("full_second_hold", 1, 2, 4);
        grant = 1'b1;
        step();
        #1;
        chk_out("full_third", 1, 1, 3);
        step();
        grant = 1'b0;
        #1;
        chk_out("full_empty", 0, 0, 0);

        // Asynchronous reset with both slots busy and a pending result
        step();
        cmd(2'd0, 4'd1, 1'b1, 4'd2, 1'b1);
        step();
        cmd(2'd0, 4'd3, 1'b1, 4'd4, 1'b1);
        step();
        update_en = 1'b0;
        #1;
        chk_out("ar_pending", 1, 1, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", int'(out_valid), 0);
        chk("ar_tag", int'(out_tag), 0);
        chk("ar_data", int'(out_data), 0);
        step();
        rst = 1'b0;
        step();
        #1;
        chk_out("ar_idle", 0, 0, 0);
        cmd(2'd0, 4'd1, 1'b1, 4'd1, 1'b1);
        #1;
        chk("ar_acc", int'(accepted), 1);
        chk("ar_acc_tag", int'(result_tag), 1);
        step();
        update_en = 1'b0;
        step();
        #1;
        chk_out("ar_result", 1, 1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
